// File: rtl/inspect_pkg.sv
// Shared types and constants for the inspection front-end: FSM states,
// frame byte positions and the default grading thresholds.
package inspect_pkg;

    typedef enum logic [1:0] {
        S_WEIGHT = 2'd0,
        S_SIZE   = 2'd1,
        S_COLOR  = 2'd2,
        S_EMIT   = 2'd3
    } inspect_state_t;

    localparam int IDX_WEIGHT = 0;
    localparam int IDX_SIZE   = 1;
    localparam int IDX_COLOR  = 2;
    localparam int NUM_FIELDS = 3;

    localparam int DEF_WEIGHT_MIN = 40;
    localparam int DEF_WEIGHT_MAX = 200;
    localparam int DEF_SIZE_MIN   = 30;
    localparam int DEF_SIZE_MAX   = 180;
    localparam int DEF_COLOR_MIN  = 64;
    localparam int DEF_COLOR_MAX  = 192;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/inspect_sampler_if.sv
// Byte stream from the sensor pins into the sampler: valid/ready handshake
// with an 8-bit payload.
interface inspect_sampler_if;

    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/inspect_sampler_range_check.sv
// Inclusive unsigned window compare of one measurement byte; an inverted
// window (LO > HI) never matches.
module range_check #(
    parameter int LO = 0,
    parameter int HI = 255
) (
    input  logic [7:0] data_i,
    output logic       ok_o
);

    localparam bit WINDOW_OPEN = (LO <= HI);

    assign ok_o = WINDOW_OPEN && (int'(data_i) >= LO) && (int'(data_i) <= HI);

endmodule

// File: rtl/inspect_sampler.sv
// Collects a weight/size/color frame and publishes held pass/fail flags with
// a one-cycle strobe. Define INSPECT_TIMEOUT_EN to abort stalled frames.
module inspect_sampler
    import inspect_pkg::*;
#(
    parameter int WEIGHT_MIN = DEF_WEIGHT_MIN,
    parameter int WEIGHT_MAX = DEF_WEIGHT_MAX,
    parameter int SIZE_MIN   = DEF_SIZE_MIN,
    parameter int SIZE_MAX   = DEF_SIZE_MAX,
    parameter int COLOR_MIN  = DEF_COLOR_MIN,
    parameter int COLOR_MAX  = DEF_COLOR_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    inspect_sampler_if.slave         in_if,
    output logic                     weight_ok_o,
    output logic                     size_ok_o,
    output logic                     color_ok_o,
    output logic                     flags_valid_o,
    output logic                     err_o,
    output logic [7:0]               frame_cnt_o
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_invalid
        $error("inspect_sampler: TIMEOUT must lie in 1..255");
    end

    inspect_state_t         state_q, state_d;
    logic [NUM_FIELDS-2:0]  part_q, part_d;
    logic [NUM_FIELDS-1:0]  ok_q, ok_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [NUM_FIELDS-1:0]  chk;
    logic                   xfer;
    logic                   abort;

    // One comparator per field; every comparator sees the live byte and the
    // state machine picks the result that belongs to the current position.
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_check
        localparam int LO = (gi == IDX_WEIGHT) ? WEIGHT_MIN :
                            (gi == IDX_SIZE)   ? SIZE_MIN   : COLOR_MIN;
        localparam int HI = (gi == IDX_WEIGHT) ? WEIGHT_MAX :
                            (gi == IDX_SIZE)   ? SIZE_MAX   : COLOR_MAX;
        range_check #(.LO(LO), .HI(HI)) u_check (
            .data_i (in_if.data_i),
            .ok_o   (chk[gi])
        );
    end

    assign in_if.ready_o = (state_q != S_EMIT);
    assign xfer          = in_if.valid_i && in_if.ready_o;

`ifdef INSPECT_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    logic [7:0] idle_q, idle_d;
    logic       err_q, err_d;

    // The idle count only accumulates mid-frame; any transfer or state exit
    // restarts it from zero. A transfer on the last allowed cycle wins.
    always_comb begin
        idle_d = '0;
        err_d  = 1'b0;
        abort  = 1'b0;
        if ((state_q == S_SIZE || state_q == S_COLOR) && !xfer) begin
            if (idle_q == IDLE_LAST) begin
                abort = 1'b1;
                err_d = 1'b1;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        part_d      = part_q;
        ok_d        = ok_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            S_WEIGHT: begin
                if (xfer) begin
                    part_d[IDX_WEIGHT] = chk[IDX_WEIGHT];
                    state_d            = S_SIZE;
                end
            end
            S_SIZE: begin
                if (xfer) begin
                    part_d[IDX_SIZE] = chk[IDX_SIZE];
                    state_d          = S_COLOR;
                end
            end
            S_COLOR: begin
                if (xfer) begin
                    ok_d[IDX_WEIGHT] = part_q[IDX_WEIGHT];
                    ok_d[IDX_SIZE]   = part_q[IDX_SIZE];
                    ok_d[IDX_COLOR]  = chk[IDX_COLOR];
                    frame_cnt_d      = frame_cnt_q + 8'd1;
                    state_d          = S_EMIT;
                end
            end
            S_EMIT: state_d = S_WEIGHT;
            default: state_d = S_WEIGHT;
        endcase
        if (abort) begin
            state_d = S_WEIGHT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WEIGHT;
            part_q      <= '0;
            ok_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            ok_q        <= ok_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign weight_ok_o   = ok_q[IDX_WEIGHT];
    assign size_ok_o     = ok_q[IDX_SIZE];
    assign color_ok_o    = ok_q[IDX_COLOR];
    assign flags_valid_o = (state_q == S_EMIT);
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_inspect_sampler.sv
// Self-checking bench for inspect_sampler: directed boundary frames plus
// randomized frames graded by a simple window model of the thresholds.
module tb_inspect_sampler;

    localparam int W_MIN = 40;
    localparam int W_MAX = 200;
    localparam int S_MIN = 30;
    localparam int S_MAX = 180;
    localparam int C_MIN = 64;
    localparam int C_MAX = 192;

    logic       clk = 1'b0;
    logic       rst;
    logic       weight_ok, size_ok, color_ok, flags_valid, err;
    logic [7:0] frame_cnt;

    inspect_sampler_if bus ();

    inspect_sampler dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (bus.slave),
        .weight_ok_o   (weight_ok),
        .size_ok_o     (size_ok),
        .color_ok_o    (color_ok),
        .flags_valid_o (flags_valid),
        .err_o         (err),
        .frame_cnt_o   (frame_cnt)
    );

    always #5 clk = ~clk;

    int       n_tests = 0;
    int       n_fail  = 0;
    bit [2:0] exp_flags = 3'b000;
    int       exp_cnt   = 0;
    int       stalls;
    int       boundary_vals [20] = '{0, 29, 30, 31, 39, 40, 41, 63, 64, 65,
                                     179, 180, 181, 191, 192, 193, 199, 200, 201, 255};

    function automatic bit in_range(input int b, input int lo, input int hi);
        return (b >= lo) && (b <= hi);
    endfunction

    function automatic logic [7:0] pick_byte();
        if ($urandom_range(0, 1) == 0)
            return 8'(boundary_vals[$urandom_range(0, 19)]);
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte starting at the current falling edge; returns at the
    // falling edge right after the accepting rising edge.
    task automatic push_byte(input logic [7:0] b, output int n_stall);
        bit rdy;
        n_stall = 0;
        bus.data_i  = b;
        bus.valid_i = 1'b1;
        while (1) begin
            rdy = bus.ready_o;
            @(negedge clk);
            if (rdy) break;
            n_stall++;
            if (n_stall > 8) begin
                check("accept_bound", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("strobe_idle", flags_valid, 1'b0);
            check("flags_held", {weight_ok, size_ok, color_ok}, exp_flags);
        end
    endtask

    task automatic frame_done(input logic [7:0] w, input logic [7:0] s, input logic [7:0] c);
        exp_flags = {in_range(w, W_MIN, W_MAX), in_range(s, S_MIN, S_MAX), in_range(c, C_MIN, C_MAX)};
        exp_cnt   = (exp_cnt + 1) % 256;
        check("strobe_emit", flags_valid, 1'b1);
        check("ready_emit", bus.ready_o, 1'b0);
        check("flags", {weight_ok, size_ok, color_ok}, exp_flags);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("err_emit", err, 1'b0);
        $display("[TB] frame w=%0d s=%0d c=%0d flags=%b cnt=%0d", w, s, c, exp_flags, exp_cnt);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [7:0] s, input logic [7:0] c, input int gap);
        int st;
        push_byte(w, st);
        if (gap > 0) idle(gap);
        push_byte(s, st);
        if (gap > 0) idle(gap);
        push_byte(c, st);
        frame_done(w, s, c);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, bus.ready_o, 1'b1);
        check({tag, "_flags"}, {weight_ok, size_ok, color_ok}, 3'b000);
        check({tag, "_strobe"}, flags_valid, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_cnt"}, frame_cnt, 8'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w, s, c;
        int         errs;

        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Back-to-back nominal frame; ready must drop for exactly one cycle.
        send_frame(8'd100, 8'd100, 8'd100, 0);
        idle(1);
        check("ready_after_emit", bus.ready_o, 1'b1);

        send_frame(8'd40,  8'd180, 8'd64,  0); idle(1);
        send_frame(8'd39,  8'd181, 8'd63,  0); idle(1);
        send_frame(8'd200, 8'd30,  8'd192, 0); idle(1);
        send_frame(8'd201, 8'd29,  8'd193, 0); idle(1);

        // Weight held on the bus through the emit cycle must not be dropped.
        send_frame(8'd100, 8'd100, 8'd100, 0);
        push_byte(8'd201, stalls);
        check("held_weight_stall", stalls, 1);
        push_byte(8'd100, stalls);
        push_byte(8'd100, stalls);
        frame_done(8'd201, 8'd100, 8'd100);
        idle(1);

`ifdef INSPECT_TIMEOUT_EN
        push_byte(8'd100, stalls);
        bus.valid_i = 1'b0;
        errs = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err) errs++;
            if (k == 16) check("timeout_err_pulse", err, 1'b1);
        end
        check("timeout_err_count", errs, 1);
        check("timeout_flags_held", {weight_ok, size_ok, color_ok}, exp_flags);
        check("timeout_cnt_held", frame_cnt, exp_cnt);
        send_frame(8'd10, 8'd100, 8'd100, 0);
        idle(1);

        push_byte(8'd100, stalls);
        bus.valid_i = 1'b0;
        repeat (15) @(negedge clk);
        push_byte(8'd100, stalls);
        bus.valid_i = 1'b0;
        errs = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (err) errs++;
        end
        check("late_byte_no_err", errs, 0);
        push_byte(8'd50, stalls);
        frame_done(8'd100, 8'd100, 8'd50);
        idle(1);
`endif

        // Reset after two bytes of a frame acts immediately, without a clock.
        send_frame(8'd100, 8'd100, 8'd100, 0);
        idle(1);
        push_byte(8'd10, stalls);
        push_byte(8'd10, stalls);
        bus.valid_i = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        exp_flags = 3'b000;
        exp_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'd50, 8'd50, 8'd50, 0);
        idle(1);

        // Randomized frames, 255 more so the counter wraps back to zero.
        for (int f = 0; f < 255; f++) begin
            w = pick_byte();
            s = pick_byte();
            c = pick_byte();
            send_frame(w, s, c, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);
        check("frame_cnt_wrap", frame_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
